pwd_ram_arbiter: RTL and testbench
==================================

Name: pwd_ram_arbiter

Overview:
- Shares the single-port password RAM (4 entries x 4 bits) between two requesters:
  - the checker (read-only), which walks digit addresses during password entry;
  - the password-update unit (read/write), which rewrites the stored digits.
- Sits between those two units and the RAM.
- Owns grant sequencing, the RAM address/write muxing, read-data return and a hold-time watchdog.

Parameters:
- ADDR_W, 2, RAM address width (digit index).
- DATA_W, 4, digit width.
- TIMEOUT, 255, maximum cycles one owner may hold the grant; must be at least 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- chk_req  in  1  checker requests the RAM; held high for the whole transaction.
- chk_addr  in  ADDR_W  checker read address.
- chk_gnt  out  1  checker owns the RAM.
- chk_rdata  out  DATA_W  read data returned to the checker.
- chk_rvalid  out  1  chk_rdata valid this cycle.
- upd_req  in  1  update unit requests the RAM.
- upd_we  in  1  write strobe; 1 = write, 0 = read.
- upd_addr  in  ADDR_W  update address.
- upd_wdata  in  DATA_W  update write data.
- upd_gnt  out  1  update unit owns the RAM.
- upd_rdata  out  DATA_W  read data returned to the update unit.
- upd_rvalid  out  1  upd_rdata valid this cycle.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_q  in  DATA_W  RAM read data, one-cycle synchronous latency.
- timeout_err  out  1  one-cycle pulse on a forced release.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, both gnt=0, both rvalid=0, both rdata=0, timeout_err=0, hold counter=0, last_owner=UPD.
- Outside a grant: ram_addr=0, ram_wdata=0, ram_we=0.
- States:
  - IDLE: no owner.
  - GNT_CHK: checker owns the RAM.
  - GNT_UPD: update unit owns the RAM.
  - BLOCK_CHK / BLOCK_UPD: the named requester has been forcibly released and is masked until it drops its request.
- IDLE arbitration:
  - Requests are sampled at the clock edge; the winner's gnt rises at that edge, so gnt is high in the cycle after the first sampled req.
  - Only one requesting: that one wins.
  - Both requesting: upd wins (priority), unless the optional feature below is compiled in.
- Access while granted:
  - An access occurs in any cycle with gnt=1 and req=1.
  - RAM muxing is combinational from the owner: ram_addr = owner addr; ram_wdata = upd_wdata; ram_we = upd_gnt & upd_req & upd_we.
  - The checker can never cause ram_we=1.
- Read return:
  - A read access in cycle N gives rvalid=1 in cycle N+1 with rdata = ram_q, routed to the requester that issued the read.
  - The return happens even if the grant drops in cycle N+1.
  - rdata holds its last value when rvalid=0.
  - Writes produce no rvalid.
- Release:
  - Owner samples req=0: gnt falls at that edge and the state returns to IDLE.
  - Re-arbitration needs one IDLE cycle, so there is a minimum one-cycle gap between grants.
- Hold counter:
  - Clears on entry to GNT_x and increments every granted cycle.
  - When it reaches TIMEOUT with req still high: gnt falls, timeout_err pulses for 1 cycle, and the state goes to BLOCK_x.
- BLOCK_x:
  - The other requester may be granted directly from BLOCK_x if it is requesting (same edge rules as IDLE).
  - Otherwise BLOCK_x returns to IDLE once the blocked req is sampled low.
  - While the blocked requester's req stays high, it is never granted.
- last_owner updates to the owner at each grant.
- Reset asserted mid-grant or mid-read: all outputs clear immediately (asynchronously); any pending rvalid is discarded.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: on a simultaneous request in IDLE, grant goes to the requester that is not last_owner. The first tie after reset goes to chk.
- Undefined: upd always wins ties. last_owner is still tracked but unused.

Test Plan:
1. Reset release, then chk_req=1, chk_addr=2, RAM[2]=4'h7 -> chk_gnt=1 the cycle after req is sampled; ram_addr=2; chk_rvalid=1 with chk_rdata=4'h7 one cycle after the access; ram_we stays 0.
2. upd_req=1, upd_we=1, addr=1, wdata=4'h9 for one access, then upd_we=0 read of addr 1 -> ram_we=1 for exactly one cycle; upd_rvalid=1 with upd_rdata=4'h9 on the read return.
3. chk_req and upd_req rise in the same cycle, both drop after 3 cycles, then both rise again:
   - macro undefined: upd granted both times;
   - macro defined: chk granted first, then upd.
4. TIMEOUT=8, chk_req held high indefinitely, upd_req idle -> chk_gnt high 8 cycles then falls; timeout_err high exactly 1 cycle; chk not regranted until chk_req low for at least 1 sampled cycle.
5. During test 4's block, upd_req=1 -> upd_gnt granted while chk is blocked; chk_gnt stays 0 throughout.
6. reset=0 asserted in the cycle after a chk read access -> chk_gnt, chk_rvalid and ram_we are 0 immediately; no rvalid appears after reset release.

Source files
------------

// File: rtl/pwd_ram_arbiter.sv
// -----------------------------------------------------------------------------
// pwd_ram_arbiter
//
// Shares the single-port password RAM between two requesters:
//   - the checker (read-only), which walks digit addresses during entry;
//   - the password-update unit (read/write), which rewrites stored digits.
// The block owns grant sequencing, the RAM address/write mux, read-data
// return to the requester that issued the read, and a hold-time watchdog
// that forcibly releases an owner after TIMEOUT granted cycles.
//
// Build option:
//   ARB_ROUND_ROBIN_EN  when defined, a simultaneous request in IDLE goes to
//                       the requester that did not own the RAM last (the
//                       first tie after reset goes to the checker). When
//                       undefined, the update unit always wins ties.
//
// Parameters:
//   ADDR_W   RAM address width (digit index)
//   DATA_W   digit width
//   TIMEOUT  maximum consecutive granted cycles per ownership (>= 1)
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   chk_req      checker request, held for the whole transaction
//   chk_addr     checker read address
//   chk_gnt      checker owns the RAM
//   chk_rdata    read data returned to the checker
//   chk_rvalid   chk_rdata valid this cycle
//   upd_req      update unit request
//   upd_we       update write strobe (1 = write, 0 = read)
//   upd_addr     update address
//   upd_wdata    update write data
//   upd_gnt      update unit owns the RAM
//   upd_rdata    read data returned to the update unit
//   upd_rvalid   upd_rdata valid this cycle
//   ram_addr     RAM address
//   ram_wdata    RAM write data
//   ram_we       RAM write enable
//   ram_q        RAM read data, one-cycle synchronous latency
//   timeout_err  one-cycle pulse on a forced release
// -----------------------------------------------------------------------------
module pwd_ram_arbiter #(
   parameter int ADDR_W  = 2,
   parameter int DATA_W  = 4,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              chk_req,
   input  logic [ADDR_W-1:0] chk_addr,
   output logic              chk_gnt,
   output logic [DATA_W-1:0] chk_rdata,
   output logic              chk_rvalid,

   input  logic              upd_req,
   input  logic              upd_we,
   input  logic [ADDR_W-1:0] upd_addr,
   input  logic [DATA_W-1:0] upd_wdata,
   output logic              upd_gnt,
   output logic [DATA_W-1:0] upd_rdata,
   output logic              upd_rvalid,

   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_q,

   output logic              timeout_err
);

   // The hold counter only ever holds 0 .. TIMEOUT-1; the last granted
   // cycle is the one in which it reads TIMEOUT-1.
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_GNT_CHK   = 3'd1,
      S_GNT_UPD   = 3'd2,
      S_BLOCK_CHK = 3'd3,
      S_BLOCK_UPD = 3'd4
   } state_t;

   typedef enum logic {
      OWN_CHK = 1'b0,
      OWN_UPD = 1'b1
   } owner_t;

   state_t            state;
   owner_t            last_owner;
   logic [CNT_W-1:0]  hold_cnt;

   // Per-requester block masks. A requester that was forcibly released stays
   // masked until its request is sampled low, even if the other requester is
   // granted and released in the meantime.
   logic              chk_blk;
   logic              upd_blk;

   logic              chk_cand;
   logic              upd_cand;
   logic              pick_chk;
   logic              pick_upd;
   logic              chk_blk_hold;
   logic              upd_blk_hold;
   logic              hold_expire;

   logic              chk_acc;
   logic              upd_rd;
   logic [DATA_W-1:0] chk_rdata_q;
   logic [DATA_W-1:0] upd_rdata_q;

   // ---------------------------------------------------------------------------
   // Arbitration between unmasked requests; only consulted in non-grant states.
   // ---------------------------------------------------------------------------
   // NOTE: every variable written in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      chk_cand = chk_req & ~chk_blk;
      upd_cand = upd_req & ~upd_blk;
      pick_chk = 1'b0;
      pick_upd = 1'b0;
      if (chk_cand && upd_cand) begin
`ifdef ARB_ROUND_ROBIN_EN
         pick_chk = (last_owner == OWN_UPD);
         pick_upd = (last_owner == OWN_CHK);
`else
         pick_upd = 1'b1;
`endif
      end else begin
         pick_chk = chk_cand;
         pick_upd = upd_cand;
      end
   end

   // A mask survives this edge only while its request is still high.
   assign chk_blk_hold = chk_blk & chk_req;
   assign upd_blk_hold = upd_blk & upd_req;
   assign hold_expire  = (hold_cnt == CNT_LAST);

   // ---------------------------------------------------------------------------
   // Grant FSM with registered grant and error outputs.
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // sees pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         chk_gnt     <= 1'b0;
         upd_gnt     <= 1'b0;
         hold_cnt    <= '0;
         last_owner  <= OWN_UPD;
         timeout_err <= 1'b0;
         chk_blk     <= 1'b0;
         upd_blk     <= 1'b0;
      end else begin
         timeout_err <= 1'b0;
         if (!chk_req) chk_blk <= 1'b0;
         if (!upd_req) upd_blk <= 1'b0;

         unique case (state)
            S_GNT_CHK: begin
               if (!chk_req) begin
                  chk_gnt <= 1'b0;
                  state   <= upd_blk_hold ? S_BLOCK_UPD : S_IDLE;
               end else if (hold_expire) begin
                  chk_gnt     <= 1'b0;
                  chk_blk     <= 1'b1;
                  timeout_err <= 1'b1;
                  state       <= S_BLOCK_CHK;
               end else begin
                  hold_cnt <= hold_cnt + CNT_W'(1);
               end
            end

            S_GNT_UPD: begin
               if (!upd_req) begin
                  upd_gnt <= 1'b0;
                  state   <= chk_blk_hold ? S_BLOCK_CHK : S_IDLE;
               end else if (hold_expire) begin
                  upd_gnt     <= 1'b0;
                  upd_blk     <= 1'b1;
                  timeout_err <= 1'b1;
                  state       <= S_BLOCK_UPD;
               end else begin
                  hold_cnt <= hold_cnt + CNT_W'(1);
               end
            end

            // IDLE and both BLOCK states arbitrate the same way; the masks
            // keep a blocked requester out of the running.
            S_IDLE, S_BLOCK_CHK, S_BLOCK_UPD: begin
               last_owner <= pick_chk ? OWN_CHK :
                             (pick_upd ? OWN_UPD : last_owner);
               if (pick_chk) begin
                  chk_gnt  <= 1'b1;
                  hold_cnt <= '0;
                  state    <= S_GNT_CHK;
               end else if (pick_upd) begin
                  upd_gnt  <= 1'b1;
                  hold_cnt <= '0;
                  state    <= S_GNT_UPD;
               end else begin
                  state <= chk_blk_hold ? S_BLOCK_CHK :
                           (upd_blk_hold ? S_BLOCK_UPD : S_IDLE);
               end
            end

            default: begin
               chk_gnt <= 1'b0;
               upd_gnt <= 1'b0;
               state   <= S_IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // RAM mux: combinational from the current owner, zero outside a grant.
   // Only the update unit can ever drive a write.
   // ---------------------------------------------------------------------------
   always_comb begin
      ram_addr  = '0;
      ram_wdata = '0;
      if (chk_gnt) begin
         ram_addr  = chk_addr;
         ram_wdata = upd_wdata;
      end else if (upd_gnt) begin
         ram_addr  = upd_addr;
         ram_wdata = upd_wdata;
      end
   end

   assign ram_we = upd_gnt & upd_req & upd_we;

   // ---------------------------------------------------------------------------
   // Read return. A read sampled at an edge makes ram_q valid for the following
   // cycle; rvalid is tagged from the access, not the grant, so the return
   // still happens if the grant drops at that same edge.
   // ---------------------------------------------------------------------------
   assign chk_acc = chk_gnt & chk_req;
   assign upd_rd  = upd_gnt & upd_req & ~upd_we;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         chk_rvalid  <= 1'b0;
         upd_rvalid  <= 1'b0;
         chk_rdata_q <= '0;
         upd_rdata_q <= '0;
      end else begin
         chk_rvalid <= chk_acc;
         upd_rvalid <= upd_rd;
         if (chk_rvalid) chk_rdata_q <= ram_q;
         if (upd_rvalid) upd_rdata_q <= ram_q;
      end
   end

   // ram_q is passed straight through on the return cycle and captured so the
   // data holds once rvalid drops.
   assign chk_rdata = chk_rvalid ? ram_q : chk_rdata_q;
   assign upd_rdata = upd_rvalid ? ram_q : upd_rdata_q;

   // ---------------------------------------------------------------------------
   // Structural invariants.
   // ---------------------------------------------------------------------------
   a_gnt_exclusive : assert property (@(posedge clk) disable iff (!reset)
                                      !(chk_gnt && upd_gnt));
   a_we_owner      : assert property (@(posedge clk) disable iff (!reset)
                                      ram_we |-> upd_gnt);
   a_err_pulse     : assert property (@(posedge clk) disable iff (!reset)
                                      timeout_err |=> !timeout_err);

endmodule

// File: tb/tb_pwd_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pwd_ram_arbiter
//
// Directed bench for pwd_ram_arbiter with a behavioural 4x4 synchronous RAM.
// Stimulus pushes the expected read data into per-requester queues; a monitor
// on the falling edge pops and compares whenever an rvalid is presented.
// Grant, write-enable and watchdog behaviour is checked inline.
// -----------------------------------------------------------------------------
module tb_pwd_ram_arbiter;

   localparam int ADDR_W  = 2;
   localparam int DATA_W  = 4;
   localparam int TIMEOUT = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic              chk_req;
   logic [ADDR_W-1:0] chk_addr;
   logic              chk_gnt;
   logic [DATA_W-1:0] chk_rdata;
   logic              chk_rvalid;
   logic              upd_req;
   logic              upd_we;
   logic [ADDR_W-1:0] upd_addr;
   logic [DATA_W-1:0] upd_wdata;
   logic              upd_gnt;
   logic [DATA_W-1:0] upd_rdata;
   logic              upd_rvalid;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic              ram_we;
   logic [DATA_W-1:0] ram_q;
   logic              timeout_err;

   logic [DATA_W-1:0] mem [4];

   logic [DATA_W-1:0] chk_exp_q [$];
   logic [DATA_W-1:0] upd_exp_q [$];

   int n_cmp = 0;
   int n_err = 0;

   pwd_ram_arbiter #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .chk_req    (chk_req),
      .chk_addr   (chk_addr),
      .chk_gnt    (chk_gnt),
      .chk_rdata  (chk_rdata),
      .chk_rvalid (chk_rvalid),
      .upd_req    (upd_req),
      .upd_we     (upd_we),
      .upd_addr   (upd_addr),
      .upd_wdata  (upd_wdata),
      .upd_gnt    (upd_gnt),
      .upd_rdata  (upd_rdata),
      .upd_rvalid (upd_rvalid),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_we     (ram_we),
      .ram_q      (ram_q),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // Synchronous RAM, read-before-write, loaded with known digits in reset.
   always @(posedge clk) begin
      if (!reset) begin
         mem[0] <= 4'h0;
         mem[1] <= 4'h3;
         mem[2] <= 4'h7;
         mem[3] <= 4'hC;
      end else if (ram_we) begin
         mem[ram_addr] <= ram_wdata;
      end
      ram_q <= mem[ram_addr];
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Read-return monitor.
   always @(negedge clk) begin
      if (chk_rvalid) begin
         if (chk_exp_q.size() == 0) check("chk_rvalid_unexpected", 32'(chk_rvalid), 32'd0);
         else check("chk_rdata", 32'(chk_rdata), 32'(chk_exp_q.pop_front()));
      end
      if (upd_rvalid) begin
         if (upd_exp_q.size() == 0) check("upd_rvalid_unexpected", 32'(upd_rvalid), 32'd0);
         else check("upd_rdata", 32'(upd_rdata), 32'(upd_exp_q.pop_front()));
      end
   end

   // Both requesters rise together, hold three cycles, then drop.
   task automatic tie_round(input bit exp_chk, input string tag);
      chk_addr = 2'd2;
      upd_addr = 2'd1;
      upd_we   = 1'b0;
      chk_req  = 1'b1;
      upd_req  = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         check({tag, "_chk_gnt"}, 32'(chk_gnt), exp_chk ? 32'd1 : 32'd0);
         check({tag, "_upd_gnt"}, 32'(upd_gnt), exp_chk ? 32'd0 : 32'd1);
         if (exp_chk) chk_exp_q.push_back(4'h7);
         else         upd_exp_q.push_back(4'h9);
      end
      step();
      chk_req = 1'b0;
      upd_req = 1'b0;
      step();
      check({tag, "_released"}, 32'({chk_gnt, upd_gnt}), 32'd0);
   endtask

   initial begin
      reset     = 1'b0;
      chk_req   = 1'b0;
      chk_addr  = '0;
      upd_req   = 1'b0;
      upd_we    = 1'b0;
      upd_addr  = '0;
      upd_wdata = '0;
      repeat (2) step();

      // Reset state.
      check("rst_chk_gnt",     32'(chk_gnt),     32'd0);
      check("rst_upd_gnt",     32'(upd_gnt),     32'd0);
      check("rst_rvalid",      32'({chk_rvalid, upd_rvalid}), 32'd0);
      check("rst_rdata",       32'({chk_rdata, upd_rdata}),   32'd0);
      check("rst_timeout_err", 32'(timeout_err), 32'd0);
      check("rst_ram_bus",     32'({ram_addr, ram_wdata, ram_we}), 32'd0);
      reset = 1'b1;
      step();

      // Test 1: checker read of address 2.
      chk_req  = 1'b1;
      chk_addr = 2'd2;
      #1 check("t1_gnt_not_yet", 32'(chk_gnt), 32'd0);
      step();
      check("t1_chk_gnt",  32'(chk_gnt),  32'd1);
      check("t1_upd_gnt",  32'(upd_gnt),  32'd0);
      check("t1_ram_addr", 32'(ram_addr), 32'd2);
      check("t1_ram_we",   32'(ram_we),   32'd0);
      chk_exp_q.push_back(4'h7);
      step();
      check("t1_ram_we_hold", 32'(ram_we), 32'd0);
      chk_req = 1'b0;
      step();
      check("t1_release",       32'(chk_gnt),  32'd0);
      check("t1_ram_addr_idle", 32'(ram_addr), 32'd0);
      check("t1_rdata_held",    32'(chk_rdata), 32'h7);

      // Test 2: update write of 9 to address 1, then read it back.
      upd_req   = 1'b1;
      upd_we    = 1'b1;
      upd_addr  = 2'd1;
      upd_wdata = 4'h9;
      #1 check("t2_we_before_gnt", 32'(ram_we), 32'd0);
      step();
      check("t2_upd_gnt",   32'(upd_gnt),   32'd1);
      check("t2_ram_we",    32'(ram_we),    32'd1);
      check("t2_ram_addr",  32'(ram_addr),  32'd1);
      check("t2_ram_wdata", 32'(ram_wdata), 32'h9);
      step();
      upd_we = 1'b0;
      #1 check("t2_we_one_cycle", 32'(ram_we), 32'd0);
      upd_exp_q.push_back(4'h9);
      step();
      upd_req = 1'b0;
      step();
      check("t2_release", 32'(upd_gnt), 32'd0);

      // Test 3: simultaneous requests, twice.
`ifdef ARB_ROUND_ROBIN_EN
      tie_round(1'b1, "t3_first");
      tie_round(1'b0, "t3_second");
`else
      tie_round(1'b0, "t3_first");
      tie_round(1'b0, "t3_second");
`endif

      // Test 4: checker holds its request past the watchdog limit.
      chk_req  = 1'b1;
      chk_addr = 2'd2;
      for (int i = 1; i <= TIMEOUT; i++) begin
         step();
         check("t4_chk_gnt_held", 32'(chk_gnt),     32'd1);
         check("t4_no_err_yet",   32'(timeout_err), 32'd0);
         chk_exp_q.push_back(4'h7);
      end
      step();
      check("t4_forced_release", 32'(chk_gnt),     32'd0);
      check("t4_timeout_err",    32'(timeout_err), 32'd1);
      step();
      check("t4_err_one_cycle",  32'(timeout_err), 32'd0);
      check("t4_chk_blocked",    32'(chk_gnt),     32'd0);

      // Test 5: update unit is served while the checker stays blocked.
      upd_req   = 1'b1;
      upd_we    = 1'b1;
      upd_addr  = 2'd3;
      upd_wdata = 4'h5;
      for (int i = 0; i < 2; i++) begin
         step();
         check("t5_upd_gnt",     32'(upd_gnt), 32'd1);
         check("t5_chk_blocked", 32'(chk_gnt), 32'd0);
      end
      upd_req = 1'b0;
      step();
      check("t5_upd_release",  32'({chk_gnt, upd_gnt}), 32'd0);
      step();
      check("t5_chk_still_blk", 32'(chk_gnt), 32'd0);
      chk_req = 1'b0;
      step();
      check("t5_chk_low", 32'(chk_gnt), 32'd0);
      chk_req = 1'b1;
      step();
      check("t5_chk_regrant", 32'(chk_gnt), 32'd1);
      chk_req = 1'b0;
      step();
      check("t5_chk_release", 32'(chk_gnt), 32'd0);

      // Test 6: reset lands while a checker read return is pending.
      chk_req  = 1'b1;
      chk_addr = 2'd2;
      step();
      check("t6_chk_gnt", 32'(chk_gnt), 32'd1);
      @(posedge clk);
      #1 check("t6_rvalid_pending", 32'(chk_rvalid), 32'd1);
      reset   = 1'b0;
      chk_req = 1'b0;
      #1;
      check("t6_gnt_cleared",    32'({chk_gnt, upd_gnt}), 32'd0);
      check("t6_rvalid_cleared", 32'(chk_rvalid), 32'd0);
      check("t6_we_cleared",     32'(ram_we),     32'd0);
      check("t6_rdata_cleared",  32'(chk_rdata),  32'd0);
      repeat (2) step();
      reset = 1'b1;
      repeat (4) step();
      check("t6_idle_after", 32'({chk_gnt, upd_gnt, chk_rvalid, upd_rvalid}), 32'd0);

      check("chk_queue_drained", 32'(chk_exp_q.size()), 32'd0);
      check("upd_queue_drained", 32'(upd_exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog expired");
   end

endmodule
